// File: rtl/cg_cgg_sequencer.sv
// cg_cgg_sequencer
// Walks all 16 input vectors of the CG_CGG network w = (a & ~b & e) | g,
// holds each vector for SETTLE_CYCLES clocks, samples the network output on
// the last edge of the hold window and compares it with the golden function.
// Reports the number of mismatching vectors and the lowest failing vector.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       begin a run (accepted only in IDLE)
//   w_in        network output under test
//   a, b, e, g  registered network inputs, vec = {a,b,e,g}
//   busy        run in progress
//   done        one-cycle pulse at run completion
//   err_cnt     mismatching vectors in the last run (0..16)
//   first_fail  lowest mismatching vector index
//   fail_valid  first_fail holds a real failure
//
// state  | meaning
// IDLE   | vector outputs parked at 0, waiting for start
// SETTLE | driving vec, counting down the settle window, sampling at count 0
// DONE   | one-cycle completion pulse, start ignored
module cg_cgg_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 3  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       w_in,
  output logic       a,
  output logic       b,
  output logic       e,
  output logic       g,
  output logic       busy,
  output logic       done,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail,
  output logic       fail_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] vec, vec_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       busy_nxt, done_nxt;
  logic [4:0] err_cnt_nxt;
  logic [3:0] first_fail_nxt;
  logic       fail_valid_nxt;
  logic       expected;
  logic       mismatch;

  // The vector register drives the network directly, so the inputs only
  // ever change on a clock edge and are 0 whenever vec is parked at 0.
  assign a = vec[3];
  assign b = vec[2];
  assign e = vec[1];
  assign g = vec[0];

  assign expected = (vec[3] & ~vec[2] & vec[1]) | vec[0];
  assign mismatch = (w_in != expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 4'd0;
      cnt        <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= 5'd0;
      first_fail <= 4'd0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err_cnt    <= err_cnt_nxt;
      first_fail <= first_fail_nxt;
      fail_valid <= fail_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    vec_nxt        = vec;
    cnt_nxt        = cnt;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    err_cnt_nxt    = err_cnt;
    first_fail_nxt = first_fail;
    fail_valid_nxt = fail_valid;

    case (state)
      IDLE: begin
        if (start) begin
          vec_nxt        = 4'd0;
          err_cnt_nxt    = 5'd0;
          fail_valid_nxt = 1'b0;
          first_fail_nxt = 4'd0;
          cnt_nxt        = CNT_LOAD;
          busy_nxt       = 1'b1;
          state_nxt      = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          if (mismatch) begin
            err_cnt_nxt = err_cnt + 5'd1;
            if (!fail_valid) begin
              first_fail_nxt = vec;
              fail_valid_nxt = 1'b1;
            end
          end
          if (vec == 4'd15) begin
            // Last vector: park the network inputs and finish, never wrap.
            vec_nxt   = 4'd0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            vec_nxt = vec + 4'd1;
            cnt_nxt = CNT_LOAD;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cg_cgg_sequencer.sv
module tb_cg_cgg_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance with S=3 and instance with S=1, each with its own network.
  logic       start3, w3, a3, b3, e3, g3, busy3, done3, fv3;
  logic [4:0] err3;
  logic [3:0] ff3;
  logic       start1, w1, a1, b1, e1, g1, busy1, done1, fv1;
  logic [4:0] err1;
  logic [3:0] ff1;

  cg_cgg_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .w_in(w3),
    .a(a3), .b(b3), .e(e3), .g(g3),
    .busy(busy3), .done(done3), .err_cnt(err3),
    .first_fail(ff3), .fail_valid(fv3)
  );

  cg_cgg_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .w_in(w1),
    .a(a1), .b(b1), .e(e1), .g(g1),
    .busy(busy1), .done(done1), .err_cnt(err1),
    .first_fail(ff1), .fail_valid(fv1)
  );

  // Network modes: 0 zero-delay correct, 1 stuck at 0, 2 stuck at 1,
  // 3 gate-level with transport delays (not 5 ns, and 8 ns, or 8 ns).
  logic [1:0] mode3, mode1;
  logic nb3 = 1'b1, and3 = 1'b0, wd3 = 1'b0;
  logic nb1 = 1'b1, and1 = 1'b0, wd1 = 1'b0;

  always @(b3) nb3 <= #5 ~b3;
  always @(a3 or nb3 or e3) and3 <= #8 (a3 & nb3 & e3);
  always @(and3 or g3) wd3 <= #8 (and3 | g3);
  always @(b1) nb1 <= #5 ~b1;
  always @(a1 or nb1 or e1) and1 <= #8 (a1 & nb1 & e1);
  always @(and1 or g1) wd1 <= #8 (and1 | g1);

  always_comb begin
    w3 = 1'b0;
    case (mode3)
      2'd0: w3 = (a3 & ~b3 & e3) | g3;
      2'd1: w3 = 1'b0;
      2'd2: w3 = 1'b1;
      default: w3 = wd3;
    endcase
  end

  always_comb begin
    w1 = 1'b0;
    case (mode1)
      2'd0: w1 = (a1 & ~b1 & e1) | g1;
      2'd1: w1 = 1'b0;
      2'd2: w1 = 1'b1;
      default: w1 = wd1;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_vec(input int d);
    return (d == 3) ? int'({a3, b3, e3, g3}) : int'({a1, b1, e1, g1});
  endfunction
  function automatic int get_busy(input int d);
    return (d == 3) ? int'(busy3) : int'(busy1);
  endfunction
  function automatic int get_done(input int d);
    return (d == 3) ? int'(done3) : int'(done1);
  endfunction
  function automatic int get_err(input int d);
    return (d == 3) ? int'(err3) : int'(err1);
  endfunction
  function automatic int get_ff(input int d);
    return (d == 3) ? int'(ff3) : int'(ff1);
  endfunction
  function automatic int get_fv(input int d);
    return (d == 3) ? int'(fv3) : int'(fv1);
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 3) start3 = v;
    else start1 = v;
  endtask

  // One full run: checks vector stepping, busy/done timing and results.
  task automatic run_check(input int d, input logic [1:0] md, input int ee,
                           input int eff, input int efv, input string nm);
    int s;
    s = (d == 3) ? 3 : 1;
    if (d == 3) mode3 = md;
    else mode1 = md;
    repeat (4) tick();
    set_start(d, 1'b1);
    tick();  // T0
    set_start(d, 1'b0);
    for (int n = 0; n < 16 * s; n++) begin
      check({nm, " vec"}, get_vec(d), n / s);
      check({nm, " busy"}, get_busy(d), 1);
      check({nm, " done early"}, get_done(d), 0);
      tick();
    end
    check({nm, " done"}, get_done(d), 1);
    check({nm, " busy end"}, get_busy(d), 0);
    check({nm, " vec park"}, get_vec(d), 0);
    check({nm, " err_cnt"}, get_err(d), ee);
    check({nm, " first_fail"}, get_ff(d), eff);
    check({nm, " fail_valid"}, get_fv(d), efv);
    tick();
    check({nm, " done fall"}, get_done(d), 0);
    repeat (3) tick();
    check({nm, " err hold"}, get_err(d), ee);
    check({nm, " ff hold"}, get_ff(d), eff);
  endtask

  typedef struct {
    int         dut;
    logic [1:0] mode;
    int         exp_err;
    int         exp_ff;
    int         exp_fv;
    string      name;
  } run_vec_t;

  run_vec_t tbl[8];
  int done_seen;

  initial begin
    // Golden ones at vec 1,3,5,7,9,10,11,13,15. Stuck-0 misses those 9
    // (first 1); stuck-1 misses the 7 zeros (first 0).
    // Delayed network, S=1, 10 ns clk: sampled value is
    // g(k) | (a(k-1) & e(k-1) & ~b(k-2)), which differs from golden at
    // k=10 (reads 0) and k=12 (reads 1): 2 errors, first 10.
    tbl[0] = '{3, 2'd0, 0, 0, 0, "s3 correct"};
    tbl[1] = '{1, 2'd1, 9, 1, 1, "s1 stuck0"};
    tbl[2] = '{1, 2'd2, 7, 0, 1, "s1 stuck1"};
    tbl[3] = '{3, 2'd3, 0, 0, 0, "s3 delayed"};
    tbl[4] = '{1, 2'd0, 0, 0, 0, "s1 correct"};
    tbl[5] = '{3, 2'd1, 9, 1, 1, "s3 stuck0"};
    tbl[6] = '{3, 2'd2, 7, 0, 1, "s3 stuck1"};
    tbl[7] = '{1, 2'd3, 2, 10, 1, "s1 delayed"};

    rst = 1'b1;
    start3 = 1'b0;
    start1 = 1'b0;
    mode3 = 2'd0;
    mode1 = 2'd0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset vec", get_vec(3), 0);
    check("reset busy", get_busy(3), 0);
    check("reset done", get_done(3), 0);
    check("reset err", get_err(3), 0);
    check("reset ff", get_ff(3), 0);
    check("reset fv", get_fv(3), 0);
    check("reset vec s1", get_vec(1), 0);
    check("reset busy s1", get_busy(1), 0);

    foreach (tbl[i])
      run_check(tbl[i].dut, tbl[i].mode, tbl[i].exp_err, tbl[i].exp_ff,
                tbl[i].exp_fv, tbl[i].name);

    // Reset mid-run at T0+20 with stuck-1 network (errors already counted).
    mode3 = 2'd2;
    repeat (4) tick();
    start3 = 1'b1;
    tick();  // T0
    start3 = 1'b0;
    repeat (19) tick();
    check("pre-reset err", get_err(3), 3);
    rst = 1'b1;
    tick();  // T0+20
    rst = 1'b0;
    check("midrst vec", get_vec(3), 0);
    check("midrst busy", get_busy(3), 0);
    check("midrst done", get_done(3), 0);
    check("midrst err", get_err(3), 0);
    check("midrst ff", get_ff(3), 0);
    check("midrst fv", get_fv(3), 0);
    done_seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (done3) done_seen++;
      if (busy3) done_seen++;
      tick();
    end
    check("midrst no done/busy", done_seen, 0);
    run_check(3, 2'd0, 0, 0, 0, "post-rst run");

    // rst and start together: rst wins.
    start3 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start3 = 1'b0;
    check("rst over start", get_busy(3), 0);
    repeat (3) tick();

    // Start pulsed mid-run is ignored; start held through done restarts.
    mode3 = 2'd1;
    start3 = 1'b1;
    tick();  // T0
    start3 = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 48; n++) begin
      check("ign vec", get_vec(3), n / 3);
      if (done3) done_seen++;
      if (n == 4) start3 = 1'b1;
      if (n == 5) start3 = 1'b0;
      if (n == 40) start3 = 1'b1;
      tick();
    end
    check("ign early done", done_seen, 0);
    check("ign done", get_done(3), 1);
    check("ign err", get_err(3), 9);
    tick();  // DONE -> IDLE, start ignored in DONE
    check("held done fall", get_done(3), 0);
    check("held busy gap", get_busy(3), 0);
    check("held err keep", get_err(3), 9);
    tick();  // start accepted in IDLE
    start3 = 1'b0;
    check("held restart busy", get_busy(3), 1);
    check("held err clear", get_err(3), 0);
    check("held fv clear", get_fv(3), 0);
    check("held vec0", get_vec(3), 0);
    done_seen = 0;
    for (int n = 0; n < 60 && done_seen == 0; n++) begin
      tick();
      if (done3) done_seen = n + 1;
    end
    check("held 2nd done at", done_seen, 48);
    check("held 2nd err", get_err(3), 9);
    check("held 2nd ff", get_ff(3), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
